// File: rtl/ex_mcu_pkg.sv
// ---------------------------------------------------------------------------
// ex_mcu_pkg
// Shared definitions for the EX-stage multi-cycle unit controller:
//   - state_e       : controller FSM states
//   - UNIT_CLMUL/DIV: unit IDs as seen on req_unit
//   - RES_W_DEFAULT : default result width of each unit
//   - id_width()    : width of an index into n items, never below 1 bit
// ---------------------------------------------------------------------------
package ex_mcu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   localparam int UNIT_CLMUL    = 0;
   localparam int UNIT_DIV      = 1;
   localparam int RES_W_DEFAULT = 64;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ex_mcu_watchdog.sv
// ---------------------------------------------------------------------------
// ex_mcu_watchdog
// Counts non-stalled cycles spent waiting on a unit and fires a one-cycle
// pulse on the TIMEOUT-th such cycle. Only built when EX_MCU_TIMEOUT_EN is
// defined.
// Ports:
//   clk, reset (sync, active-high)
//   i_active : controller is waiting on a unit (RUN or DRAIN)
//   i_clear  : controller enters RUN or DRAIN next cycle; restart count
//   i_stall  : pipeline frozen, cycle does not count
//   i_cancel : the unit completed (or the op is being flushed) this cycle
//   o_fire   : watchdog expiry pulse
// ---------------------------------------------------------------------------
module ex_mcu_watchdog
   import ex_mcu_pkg::*;
#(
   parameter  int TIMEOUT = 64,
   localparam int CNT_W   = id_width(TIMEOUT)
) (
   input  logic clk,
   input  logic reset,
   input  logic i_active,
   input  logic i_clear,
   input  logic i_stall,
   input  logic i_cancel,
   output logic o_fire
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_fire;

   // r_cnt holds the cycles already counted, so this cycle is the
   // TIMEOUT-th one when r_cnt sits at TIMEOUT-1. A completing unit wins.
   assign w_fire = i_active && !i_stall && !i_cancel
                && (r_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_active && !i_stall && !w_fire) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_fire = w_fire;

endmodule

// File: rtl/ex_mcu_ctrl.sv
// ---------------------------------------------------------------------------
// ex_mcu_ctrl
// Sequencer for the EX-stage multi-cycle units (clmul, divider). Starts the
// selected unit with a one-cycle pulse, stalls the pipeline until the result
// is available, parks a result that completes under an external stall, and
// drains a flushed operation before accepting the next one.
// Optional feature: define EX_MCU_TIMEOUT_EN to add a watchdog that aborts an
// operation after TIMEOUT non-stalled busy cycles (o_timeout_trap).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   i_req_valid/unit    : EX instruction needs unit i_req_unit
//   i_flush             : kill the current EX instruction
//   i_ext_stall         : pipeline frozen by an external cause
//   o_unit_start        : one-hot start pulse to the units
//   o_unit_stall        : freeze all units (mirrors i_ext_stall)
//   i_unit_done/res     : per-unit completion and result (unit k at k*RES_W)
//   o_stall_req         : stall the pipeline while waiting on a unit
//   o_res_valid/o_res   : result of the current instruction
//   o_busy              : FSM not IDLE
//   o_timeout_trap      : watchdog fired (0 without EX_MCU_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module ex_mcu_ctrl
   import ex_mcu_pkg::*;
#(
   parameter  int N_UNITS = 2,
   parameter  int RES_W   = RES_W_DEFAULT,
   parameter  int TIMEOUT = 64,
   localparam int UID_W   = id_width(N_UNITS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_req_valid,
   input  logic [UID_W-1:0]         i_req_unit,
   input  logic                     i_flush,
   input  logic                     i_ext_stall,
   output logic [N_UNITS-1:0]       o_unit_start,
   output logic                     o_unit_stall,
   input  logic [N_UNITS-1:0]       i_unit_done,
   input  logic [N_UNITS*RES_W-1:0] i_unit_res,
   output logic                     o_stall_req,
   output logic                     o_res_valid,
   output logic [RES_W-1:0]         o_res,
   output logic                     o_busy,
   output logic                     o_timeout_trap
);

   localparam logic [UID_W:0] N_UNITS_EXT = (UID_W + 1)'(N_UNITS);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [UID_W-1:0] r_sel;
   logic [RES_W-1:0] r_hold;

   logic             w_req_ok;
   logic             w_done_sel;
   logic [RES_W-1:0] w_res_sel;
   logic             w_start;
   logic             w_capture;
   logic             w_timeout;

   // Out-of-range IDs (possible when N_UNITS is not a power of two) are
   // treated as no request at all.
   assign w_req_ok   = i_req_valid && ({1'b0, i_req_unit} < N_UNITS_EXT);
   assign w_done_sel = i_unit_done[r_sel];
   assign w_res_sel  = i_unit_res[int'(r_sel) * RES_W +: RES_W];

   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_capture   = 1'b0;
      o_res_valid = 1'b0;
      o_res       = '0;
      case (r_state)
         IDLE: begin
            if (w_req_ok && !i_flush && !i_ext_stall) begin
               w_start     = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            // Flush beats a simultaneous done; that result is dropped.
            if (i_flush) begin
               w_state_nxt = DRAIN;
            end else if (w_done_sel) begin
               if (!i_ext_stall) begin
                  o_res_valid = 1'b1;
                  o_res       = w_res_sel;
                  w_state_nxt = IDLE;
               end else begin
                  w_capture   = 1'b1;
                  w_state_nxt = HOLD;
               end
            end else if (w_timeout) begin
               w_state_nxt = IDLE;
            end
         end
         HOLD: begin
            if (i_flush) begin
               w_state_nxt = IDLE;
            end else begin
               o_res_valid = 1'b1;
               o_res       = r_hold;
               if (!i_ext_stall) begin
                  w_state_nxt = IDLE;
               end
            end
         end
         DRAIN: begin
            if (w_done_sel || w_timeout) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_sel   <= '0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_sel <= i_req_unit;
         end
         if (w_capture) begin
            r_hold <= w_res_sel;
         end
      end
   end

   assign o_unit_start   = w_start ? (N_UNITS'(1) << i_req_unit) : '0;
   assign o_unit_stall   = i_ext_stall;
   // The start cycle itself stalls; a timeout releases the pipeline.
   assign o_stall_req    = w_req_ok && !o_res_valid && !w_timeout;
   assign o_busy         = (r_state != IDLE);
   assign o_timeout_trap = w_timeout;

`ifdef EX_MCU_TIMEOUT_EN
   logic w_wd_active;
   logic w_wd_clear;
   logic w_wd_cancel;

   assign w_wd_active = (r_state == RUN) || (r_state == DRAIN);
   assign w_wd_clear  = ((w_state_nxt == RUN) || (w_state_nxt == DRAIN))
                     && (w_state_nxt != r_state);
   // A flush in RUN restarts the count in DRAIN instead of trapping.
   assign w_wd_cancel = w_done_sel || ((r_state == RUN) && i_flush);

   ex_mcu_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .reset    (reset),
      .i_active (w_wd_active),
      .i_clear  (w_wd_clear),
      .i_stall  (i_ext_stall),
      .i_cancel (w_wd_cancel),
      .o_fire   (w_timeout)
   );
`else
   logic w_timeout_unused;

   assign w_timeout        = 1'b0;
   assign w_timeout_unused = (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_ex_mcu_ctrl.sv
`timescale 1ns/1ps
module tb_ex_mcu_ctrl;

   localparam int N_RAND = 800;
`ifdef EX_MCU_TIMEOUT_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          reset;
   always #5 clk = ~clk;

   // main DUT, two units
   logic          req_valid;
   logic [0:0]    req_unit;
   logic          flush;
   logic          ext_stall;
   logic [1:0]    unit_start;
   logic          unit_stall;
   logic [1:0]    unit_done;
   logic [127:0]  unit_res;
   logic          stall_req;
   logic          res_valid;
   logic [63:0]   res;
   logic          busy;
   logic          timeout_trap;

   // second DUT, three units, to reach an out-of-range ID
   logic          rv3;
   logic [1:0]    ru3;
   logic          zero3;
   logic [2:0]    start3;
   logic          ustall3;
   logic [2:0]    done3;
   logic [191:0]  res3_in;
   logic          sreq3;
   logic          rvalid3;
   logic [63:0]   res3;
   logic          busy3;
   logic          trap3;

   int            n_checks = 0;
   int            n_pass   = 0;
   logic [63:0]   sb_q[$];
   bit            sb_en = 1'b0;

   ex_mcu_ctrl #(.N_UNITS(2), .RES_W(64), .TIMEOUT(TMO)) u_dut (
      .clk(clk), .reset(reset),
      .i_req_valid(req_valid), .i_req_unit(req_unit),
      .i_flush(flush), .i_ext_stall(ext_stall),
      .o_unit_start(unit_start), .o_unit_stall(unit_stall),
      .i_unit_done(unit_done), .i_unit_res(unit_res),
      .o_stall_req(stall_req), .o_res_valid(res_valid), .o_res(res),
      .o_busy(busy), .o_timeout_trap(timeout_trap)
   );

   ex_mcu_ctrl #(.N_UNITS(3), .RES_W(64), .TIMEOUT(TMO)) u_dut3 (
      .clk(clk), .reset(reset),
      .i_req_valid(rv3), .i_req_unit(ru3),
      .i_flush(zero3), .i_ext_stall(zero3),
      .o_unit_start(start3), .o_unit_stall(ustall3),
      .i_unit_done(done3), .i_unit_res(res3_in),
      .o_stall_req(sreq3), .o_res_valid(rvalid3), .o_res(res3),
      .o_busy(busy3), .o_timeout_trap(trap3)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic drive(input logic rv, input logic [0:0] ru, input logic fl,
                        input logic st, input logic [1:0] dn, input logic [127:0] rs);
      @(posedge clk); #1;
      req_valid = rv; req_unit = ru; flush = fl; ext_stall = st;
      unit_done = dn; unit_res = rs;
      @(negedge clk);
   endtask

   task automatic check_out(input string tag, input logic [1:0] e_start, input logic e_sreq,
                            input logic e_rv, input logic [63:0] e_res, input logic e_busy,
                            input logic e_trap);
      check({tag, ".start"}, 64'(unit_start), 64'(e_start));
      check({tag, ".stall_req"}, 64'(stall_req), 64'(e_sreq));
      check({tag, ".res_valid"}, 64'(res_valid), 64'(e_rv));
      check({tag, ".res"}, res, e_res);
      check({tag, ".busy"}, 64'(busy), 64'(e_busy));
      check({tag, ".unit_stall"}, 64'(unit_stall), 64'(ext_stall));
      check({tag, ".trap"}, 64'(timeout_trap), 64'(e_trap));
   endtask

   // Scoreboard monitor: every delivered result must be the next expected one.
   always @(negedge clk) begin
      if (sb_en && res_valid) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected_res: got %0h required none", res);
         end else begin
            check("sb_res", res, sb_q.pop_front());
         end
      end
   end

   // Reference model state: the operation in flight and any parked result.
   bit          m_op;
   int          m_unit;
   bit          m_killed;
   int          m_cnt;
   bit          m_held;
   logic [63:0] m_hval;

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: got expired required finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; req_valid = 0; req_unit = 0; flush = 0; ext_stall = 0;
      unit_done = 0; unit_res = 0;
      rv3 = 0; ru3 = 0; zero3 = 0; done3 = 0; res3_in = 0;
      drive(0, 0, 0, 0, 2'b00, '0);
      drive(0, 0, 0, 0, 2'b00, '0);
      check_out("rst", 2'b00, 0, 0, 64'h0, 0, 0);
      reset = 1'b0;

      // basic pass-through, done at cycle 4
      drive(1, 0, 0, 0, 2'b00, '0);
      check_out("t1.c0", 2'b01, 1, 0, 64'h0, 0, 0);
      for (int c = 1; c <= 3; c++) begin
         drive(1, 0, 0, 0, 2'b00, '0);
         check_out($sformatf("t1.c%0d", c), 2'b00, 1, 0, 64'h0, 1, 0);
      end
      drive(1, 0, 0, 0, 2'b01, {64'hAAAA, 64'h1234});
      check_out("t1.c4", 2'b00, 0, 1, 64'h1234, 1, 0);
      drive(0, 0, 0, 0, 2'b00, '0);
      check_out("t1.c5", 2'b00, 0, 0, 64'h0, 0, 0);

      // done under external stall, result parked in HOLD
      drive(1, 0, 0, 0, 2'b00, '0);
      check_out("t2.c0", 2'b01, 1, 0, 64'h0, 0, 0);
      drive(1, 0, 0, 0, 2'b00, '0);
      drive(1, 0, 0, 0, 2'b00, '0);
      check_out("t2.c2", 2'b00, 1, 0, 64'h0, 1, 0);
      drive(1, 0, 0, 1, 2'b01, {64'h0, 64'hCAFE_0001});
      check_out("t2.c3", 2'b00, 1, 0, 64'h0, 1, 0);
      for (int c = 4; c <= 6; c++) begin
         drive(1, 0, 0, (c < 6), 2'b00, {64'h0, 64'hBAD0_0000 + 64'(c)});
         check_out($sformatf("t2.c%0d", c), 2'b00, 0, 1, 64'hCAFE_0001, 1, 0);
      end
      drive(0, 0, 0, 0, 2'b00, '0);
      check_out("t2.c7", 2'b00, 0, 0, 64'h0, 0, 0);

      // flush in RUN, drain, then unit 1 starts
      drive(1, 0, 0, 0, 2'b00, '0);
      drive(1, 0, 0, 0, 2'b00, '0);
      drive(1, 0, 1, 0, 2'b00, '0);
      check_out("t3.c2", 2'b00, 1, 0, 64'h0, 1, 0);
      drive(1, 1, 0, 0, 2'b00, '0);
      drive(1, 1, 0, 0, 2'b00, '0);
      check_out("t3.c4", 2'b00, 1, 0, 64'h0, 1, 0);
      drive(1, 1, 0, 0, 2'b01, {64'h0, 64'h5555});
      check_out("t3.c5", 2'b00, 1, 0, 64'h0, 1, 0);
      drive(1, 1, 0, 0, 2'b00, '0);
      check_out("t3.c6", 2'b10, 1, 0, 64'h0, 0, 0);
      drive(1, 1, 0, 0, 2'b10, {64'h7777, 64'h1});
      check_out("t3.c7", 2'b00, 0, 1, 64'h7777, 1, 0);
      drive(0, 0, 0, 0, 2'b00, '0);
      check_out("t3.c8", 2'b00, 0, 0, 64'h0, 0, 0);

      // flush and done in the same cycle
      drive(1, 1, 0, 0, 2'b00, '0);
      check_out("t4.c0", 2'b10, 1, 0, 64'h0, 0, 0);
      drive(1, 1, 1, 0, 2'b10, {64'h9999, 64'h0});
      check_out("t4.c1", 2'b00, 1, 0, 64'h0, 1, 0);
      drive(0, 0, 0, 0, 2'b00, '0);
      check_out("t4.c2", 2'b00, 0, 0, 64'h0, 1, 0);
      drive(0, 0, 0, 0, 2'b10, {64'h9999, 64'h0});
      check_out("t4.c3", 2'b00, 0, 0, 64'h0, 1, 0);
      drive(0, 0, 0, 0, 2'b00, '0);
      check_out("t4.c4", 2'b00, 0, 0, 64'h0, 0, 0);

      // stray done from the unselected unit
      drive(1, 0, 0, 0, 2'b00, '0);
      drive(1, 0, 0, 0, 2'b10, {64'h1111, 64'h2222});
      check_out("t5.c1", 2'b00, 1, 0, 64'h0, 1, 0);
      drive(1, 0, 0, 0, 2'b01, {64'h1111, 64'hD00D});
      check_out("t5.c2", 2'b00, 0, 1, 64'hD00D, 1, 0);
      drive(0, 0, 0, 0, 2'b00, '0);
      check_out("t5.c3", 2'b00, 0, 0, 64'h0, 0, 0);

      // reset in RUN
      drive(1, 0, 0, 0, 2'b00, '0);
      drive(1, 0, 0, 0, 2'b00, '0);
      check_out("t6.run", 2'b00, 1, 0, 64'h0, 1, 0);
      reset = 1'b1;
      drive(0, 0, 0, 0, 2'b01, {64'h0, 64'hEEEE});
      check_out("t6.rst", 2'b00, 0, 0, 64'h0, 0, 0);
      reset = 1'b0;
      drive(0, 0, 0, 0, 2'b00, '0);

      // out-of-range ID on the three-unit instance, then a legal unit 2 op
      @(posedge clk); #1; rv3 = 1; ru3 = 2'd3;
      @(negedge clk);
      check("n3.bad.start", 64'(start3), 64'h0);
      check("n3.bad.stall_req", 64'(sreq3), 64'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("n3.bad.busy", 64'(busy3), 64'h0);
      @(posedge clk); #1; ru3 = 2'd2;
      @(negedge clk);
      check("n3.ok.start", 64'(start3), 64'h4);
      check("n3.ok.stall_req", 64'(sreq3), 64'h1);
      @(posedge clk); #1; done3 = 3'b100; res3_in = {64'hC3C3, 128'h0};
      @(negedge clk);
      check("n3.ok.res_valid", 64'(rvalid3), 64'h1);
      check("n3.ok.res", res3, 64'hC3C3);
      @(posedge clk); #1; rv3 = 0; done3 = 0;
      @(negedge clk);
      check("n3.ok.busy", 64'(busy3), 64'h0);
      check("n3.trap", 64'(trap3), 64'h0);

      // unit never completes, 3 stalled cycles mid-run
      for (int c = 0; c <= 12; c++) begin
         drive(WD_EN ? (c < 12) : 1'b1, 0, 0, (c >= 3 && c <= 5), 2'b00, '0);
         if (WD_EN)
            check_out($sformatf("wd.c%0d", c), (c == 0) ? 2'b01 : 2'b00, (c < 11), 0, 64'h0,
                      (c >= 1 && c <= 11), (c == 11));
         else
            check_out($sformatf("wd.c%0d", c), (c == 0) ? 2'b01 : 2'b00, 1, 0, 64'h0,
                      (c >= 1), 0);
      end
      if (!WD_EN) begin
         drive(1, 0, 0, 0, 2'b01, {64'h0, 64'h4242});
         check_out("wd.done", 2'b00, 0, 1, 64'h4242, 1, 0);
         drive(0, 0, 0, 0, 2'b00, '0);
         check_out("wd.idle", 2'b00, 0, 0, 64'h0, 0, 0);
      end

      // randomized run against the reference model
      m_op = 0; m_unit = 0; m_killed = 0; m_cnt = 0; m_held = 0; m_hval = '0;
      sb_en = 1'b1;
      for (int cyc = 0; cyc < N_RAND + 8; cyc++) begin
         logic        rv, fl, st, e_rv, e_trap, e_busy, d;
         logic [0:0]  ru;
         logic [1:0]  dn, e_start;
         logic [127:0] rs;
         logic [63:0] e_res;
         @(posedge clk); #1;
         if (cyc >= N_RAND) begin
            rv = 0; ru = 0; fl = 0; st = 0; dn = 2'b11;
         end else begin
            rv = ($urandom_range(0, 9) < 7);
            ru = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 3) == 0);
            dn = {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)};
         end
         rs = {$urandom, $urandom, $urandom, $urandom};
         req_valid = rv; req_unit = ru; flush = fl; ext_stall = st;
         unit_done = dn; unit_res = rs;

         e_busy = m_op || m_held;
         e_start = 2'b00; e_rv = 0; e_res = '0; e_trap = 0;
         if (m_held) begin
            if (!fl) begin e_rv = 1; e_res = m_hval; end
            if (fl || !st) m_held = 0;
         end else if (m_op) begin
            d = dn[m_unit];
            if (!m_killed && fl) begin
               m_killed = 1; m_cnt = 0;
            end else if (d) begin
               if (!m_killed) begin
                  if (!st) begin e_rv = 1; e_res = rs[m_unit*64 +: 64]; end
                  else begin m_held = 1; m_hval = rs[m_unit*64 +: 64]; end
               end
               m_op = 0;
            end else if (!st) begin
               m_cnt++;
               if (WD_EN && m_cnt == TMO) begin e_trap = 1; m_op = 0; end
            end
         end else if (rv && !fl && !st) begin
            e_start = 2'b01 << ru;
            m_op = 1; m_unit = int'(ru); m_killed = 0; m_cnt = 0;
         end
         if (e_rv) sb_q.push_back(e_res);

         @(negedge clk);
         check_out($sformatf("rnd%0d", cyc), e_start, rv && !e_rv && !e_trap, e_rv, e_res,
                   e_busy, e_trap);
      end
      @(posedge clk);
      sb_en = 1'b0;
      check("sb_drained", 64'(sb_q.size()), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
